chkn_min1min2_stream: RTL and testbench

Streaming check-node min-finder for the layered min-sum decoder. It accepts a check-node row as a sequence of LANES-wide LLR beats and supports any degree up to MAX_DEG. It accumulates across beats the sign parity, min1, min2 and the global index of min1, then presents the result with a valid/ready handshake toward the CHKN update stage.

---
 rtl/chkn_min1min2_stream.sv | 193 +++++++++++++++++++
 tb/tb_chkn_min1min2_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/chkn_min1min2_stream.sv
// chkn_min1min2_stream: streaming check-node min1/min2/index/sign finder over LANES-wide beats.
// Define OFFSET_MINSUM_EN to subtract OFFSET (floored at 0) from min1/min2 at output load.
module chkn_min1min2_stream #(
  parameter int WIDTH_LLR = 8,
  parameter int LANES     = 16,
  parameter int MAX_DEG   = 64,
  parameter int OFFSET    = 1,
  parameter int WIDTH_IDX = $clog2(MAX_DEG)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LANES*WIDTH_LLR-1:0] inSig,
  input  logic [LANES-1:0]           laneMaskIn,
  input  logic                       firstIn,
  input  logic                       lastIn,
  input  logic                       validIn,
  output logic                       inReady,
  output logic [WIDTH_LLR-1:0]       MinSig1,
  output logic [WIDTH_LLR-1:0]       MinSig2,
  output logic [WIDTH_IDX-1:0]       IdxMinSig1,
  output logic [MAX_DEG-1:0]         outSigSgn,
  output logic                       ValidOut,
  input  logic                       outReady,
  output logic                       errOut
);
  localparam int WM    = WIDTH_LLR - 1;
  localparam int BEATS = MAX_DEG / LANES;
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [WM-1:0] MAXMAG = '1;
  localparam logic [0:0] IDLE = 1'b0, ACC = 1'b1;
`ifdef OFFSET_MINSUM_EN
  localparam bit OFS_EN = 1'b1;
`else
  localparam bit OFS_EN = 1'b0;
`endif
  localparam logic [WM-1:0] OFS = OFS_EN ? WM'(OFFSET) : '0;

  function automatic logic [WM-1:0] sat_abs(input logic [WIDTH_LLR-1:0] x);
    logic [WIDTH_LLR-1:0] n;
    n = -x;
    return x[WIDTH_LLR-1] ? (n[WIDTH_LLR-1] ? MAXMAG : n[WM-1:0]) : x[WM-1:0];
  endfunction

  // Keys carry an "invalid" MSB so a masked lane loses every tie against a real 127.
  logic [WIDTH_LLR-1:0] key [LANES];
  logic [LANES-1:0]     bsgn;
  logic [WIDTH_LLR-1:0] k1, k2;
  logic [LW-1:0]        i1;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      key[l]  = laneMaskIn[l] ? {1'b0, sat_abs(inSig[(LANES-1-l)*WIDTH_LLR +: WIDTH_LLR])} : {1'b1, MAXMAG};
      bsgn[l] = laneMaskIn[l] & inSig[(LANES-l)*WIDTH_LLR-1];
    end
  end

  always_comb begin
    k1 = '1;
    k2 = '1;
    i1 = '0;
    for (int l = 0; l < LANES; l++)
      if (key[l] < k1) begin
        k2 = k1;
        k1 = key[l];
        i1 = LW'(l);
      end else if (key[l] < k2) k2 = key[l];
  end

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, bidx;
  logic                 stall, accept, start, ovf, err_q, err_d;
  logic                 s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d, s1_par_q, s1_par_d;
  logic [WM-1:0]        s1_m1_q, s1_m1_d, s1_m2_q, s1_m2_d;
  logic [WIDTH_IDX-1:0] s1_idx_q, s1_idx_d;
  logic [BW-1:0]        s1_beat_q, s1_beat_d;
  logic [LANES-1:0]     s1_sgn_q, s1_sgn_d, s1_msk_q, s1_msk_d;

  always_comb begin
    stall      = s1_v_q & s1_last_q & ValidOut & ~outReady;
    accept     = validIn & ~stall;
    start      = firstIn | (state_q == IDLE);
    ovf        = ~start & (cnt_q == CW'(BEATS));
    bidx       = start ? '0 : cnt_q;
    state_d    = accept ? ((ovf | lastIn) ? IDLE : ACC) : state_q;
    cnt_d      = accept ? (ovf ? '0 : bidx + 1'b1) : cnt_q;
    err_d      = accept & ((~firstIn & (state_q == IDLE)) | (firstIn & (state_q == ACC)) | ovf);
    s1_v_d     = stall ? s1_v_q : accept & ~ovf;
    s1_first_d = stall ? s1_first_q : start;
    s1_last_d  = stall ? s1_last_q : lastIn;
    s1_par_d   = stall ? s1_par_q : ^bsgn;
    s1_m1_d    = stall ? s1_m1_q : (k1[WM] ? MAXMAG : k1[WM-1:0]);
    s1_m2_d    = stall ? s1_m2_q : (k2[WM] ? MAXMAG : k2[WM-1:0]);
    s1_idx_d   = stall ? s1_idx_q : WIDTH_IDX'(int'(bidx) * LANES + int'(i1));
    s1_beat_d  = stall ? s1_beat_q : BW'(bidx);
    s1_sgn_d   = stall ? s1_sgn_q : bsgn;
    s1_msk_d   = stall ? s1_msk_q : laneMaskIn;
  end

  logic [WM-1:0]        a1_q, a1_d, a2_q, a2_d, m1_n, m2_n, o1, o2;
  logic [WIDTH_IDX-1:0] ai_q, ai_d, i_n, idx_q, idx_d;
  logic                 ap_q, ap_d, p_n, upd, load, win, vout_q, vout_d;
  logic [MAX_DEG-1:0]   sg_q, sg_d, ev_q, ev_d, sg_n, ev_n, osg_q, osg_d;
  logic [WIDTH_LLR-1:0] min1_q, min1_d, min2_q, min2_d;

  // The accumulator wins magnitude ties, so earlier (lower-index) elements keep min1.
  always_comb begin
    upd    = s1_v_q & ~stall;
    load   = upd & s1_last_q;
    win    = s1_first_q | (s1_m1_q < a1_q);
    m1_n   = win ? s1_m1_q : a1_q;
    i_n    = win ? s1_idx_q : ai_q;
    m2_n   = s1_first_q ? s1_m2_q : win ? ((a1_q < s1_m2_q) ? a1_q : s1_m2_q) : ((a2_q < s1_m1_q) ? a2_q : s1_m1_q);
    p_n    = s1_par_q ^ (~s1_first_q & ap_q);
    sg_n   = (MAX_DEG'(s1_sgn_q) << (int'(s1_beat_q) * LANES)) | (s1_first_q ? '0 : sg_q);
    ev_n   = (MAX_DEG'(s1_msk_q) << (int'(s1_beat_q) * LANES)) | (s1_first_q ? '0 : ev_q);
    o1     = (m1_n > OFS) ? m1_n - OFS : '0;
    o2     = (m2_n > OFS) ? m2_n - OFS : '0;
    a1_d   = upd ? m1_n : a1_q;
    a2_d   = upd ? m2_n : a2_q;
    ai_d   = upd ? i_n : ai_q;
    ap_d   = upd ? p_n : ap_q;
    sg_d   = upd ? sg_n : sg_q;
    ev_d   = upd ? ev_n : ev_q;
    min1_d = load ? {1'b0, o1} : min1_q;
    min2_d = load ? {1'b0, o2} : min2_q;
    idx_d  = load ? i_n : idx_q;
    osg_d  = load ? (sg_n ^ {MAX_DEG{p_n}}) & ev_n : osg_q;
    vout_d = load | (vout_q & ~outReady);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_par_q   <= 1'b0;
      s1_m1_q    <= '0;
      s1_m2_q    <= '0;
      s1_idx_q   <= '0;
      s1_beat_q  <= '0;
      s1_sgn_q   <= '0;
      s1_msk_q   <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      ai_q       <= '0;
      ap_q       <= 1'b0;
      sg_q       <= '0;
      ev_q       <= '0;
      min1_q     <= '0;
      min2_q     <= '0;
      idx_q      <= '0;
      osg_q      <= '0;
      vout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      s1_v_q     <= s1_v_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_par_q   <= s1_par_d;
      s1_m1_q    <= s1_m1_d;
      s1_m2_q    <= s1_m2_d;
      s1_idx_q   <= s1_idx_d;
      s1_beat_q  <= s1_beat_d;
      s1_sgn_q   <= s1_sgn_d;
      s1_msk_q   <= s1_msk_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      ai_q       <= ai_d;
      ap_q       <= ap_d;
      sg_q       <= sg_d;
      ev_q       <= ev_d;
      min1_q     <= min1_d;
      min2_q     <= min2_d;
      idx_q      <= idx_d;
      osg_q      <= osg_d;
      vout_q     <= vout_d;
    end

  assign inReady    = ~stall;
  assign MinSig1    = min1_q;
  assign MinSig2    = min2_q;
  assign IdxMinSig1 = idx_q;
  assign outSigSgn  = osg_q;
  assign ValidOut   = vout_q;
  assign errOut     = err_q;
endmodule

// File: tb/tb_chkn_min1min2_stream.sv
// tb_chkn_min1min2_stream: directed vectors with hand-computed results for the check-node min finder.
module tb_chkn_min1min2_stream;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [127:0] inSig = '0;
  logic [15:0]  laneMaskIn = '0;
  logic         firstIn = 1'b0, lastIn = 1'b0, validIn = 1'b0, outReady = 1'b1;
  logic         inReady, ValidOut, errOut;
  logic [7:0]   MinSig1, MinSig2;
  logic [5:0]   IdxMinSig1;
  logic [63:0]  outSigSgn;
  logic [7:0]   e [64];
  logic         seen;
  int           n_vec = 0, n_bad = 0;

  chkn_min1min2_stream dut (
    .clk(clk), .rst_n(rst_n), .inSig(inSig), .laneMaskIn(laneMaskIn),
    .firstIn(firstIn), .lastIn(lastIn), .validIn(validIn), .inReady(inReady),
    .MinSig1(MinSig1), .MinSig2(MinSig2), .IdxMinSig1(IdxMinSig1), .outSigSgn(outSigSgn),
    .ValidOut(ValidOut), .outReady(outReady), .errOut(errOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    foreach (e[i]) e[i] = v;
  endtask

  task automatic put(input int b, input logic [15:0] m, input logic f, input logic l);
    int n = 0;
    for (int k = 0; k < 16; k++) inSig[(15-k)*8 +: 8] = e[b*16+k];
    laneMaskIn = m;
    firstIn = f;
    lastIn = l;
    validIn = 1'b1;
    while (!inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) chk("put_ready_timeout", {63'd0, inReady}, 64'd1);
    @(negedge clk);
    validIn = 1'b0;
  endtask

  task automatic expect_row(input string t, input logic [7:0] m1, input logic [7:0] m2,
                            input logic [5:0] ix, input logic [63:0] sg);
    int n = 0;
    while (!ValidOut && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({t, "_valid"}, {63'd0, ValidOut}, 64'd1);
    chk({t, "_min1"}, {56'd0, MinSig1}, {56'd0, m1});
    chk({t, "_min2"}, {56'd0, MinSig2}, {56'd0, m2});
    chk({t, "_idx"}, {58'd0, IdxMinSig1}, {58'd0, ix});
    chk({t, "_sgn"}, outSigSgn, sg);
    @(negedge clk);
  endtask

  initial begin
    fill(8'd0);
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, ValidOut}, 64'd0);
    chk("rst_ready", {63'd0, inReady}, 64'd1);
    chk("rst_err", {63'd0, errOut}, 64'd0);
    chk("rst_min1", {56'd0, MinSig1}, 64'd0);
    chk("rst_sgn", outSigSgn, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int l = 0; l < 16; l++) e[l] = 8'(10 + l);
    e[7] = 8'hFD;
    put(0, 16'hFFFF, 1'b1, 1'b1);
    chk("t1_lat1", {63'd0, ValidOut}, 64'd0);
    chk("t1_err", {63'd0, errOut}, 64'd0);
    @(negedge clk);
    chk("t1_lat2", {63'd0, ValidOut}, 64'd1);
    expect_row("t1", 8'd3, 8'd10, 6'd7, 64'h0000_0000_0000_FF7F);

    fill(8'd50);
    e[5] = 8'd4;
    e[37] = 8'd2;
    e[63] = 8'hC4;
    for (int b = 0; b < 4; b++) put(b, 16'hFFFF, b == 0, b == 3);
    expect_row("t2", 8'd2, 8'd4, 6'd37, 64'h7FFF_FFFF_FFFF_FFFF);

    fill(8'd40);
    e[3] = 8'd5;
    e[9] = 8'd5;
    e[20] = 8'd5;
    put(0, 16'hFFFF, 1'b1, 1'b0);
    put(1, 16'hFFFF, 1'b0, 1'b1);
    expect_row("tie", 8'd5, 8'd5, 6'd3, 64'd0);

    fill(8'h81);
    e[0] = 8'h80;
    e[1] = 8'd50;
    put(0, 16'h0003, 1'b1, 1'b1);
    expect_row("sat", 8'd50, 8'd127, 6'd1, 64'h2);

    fill(8'h81);
    e[0] = 8'd9;
    put(0, 16'h0001, 1'b1, 1'b1);
    expect_row("deg1", 8'd9, 8'd127, 6'd0, 64'd0);

    fill(8'hFF);
    for (int l = 0; l < 16; l++) e[l] = 8'd60;
    e[3] = 8'hEC;
    for (int l = 16; l < 24; l++) e[l] = 8'd30;
    put(0, 16'hFFFF, 1'b1, 1'b0);
    put(1, 16'h00FF, 1'b0, 1'b1);
    expect_row("mask", 8'd20, 8'd30, 6'd3, 64'h0000_0000_00FF_FFF7);

    outReady = 1'b0;
    fill(8'd70);
    for (int l = 0; l < 16; l++) e[l] = 8'(10 + l);
    put(0, 16'hFFFF, 1'b1, 1'b1);
    fill(8'd70);
    e[4] = 8'd7;
    put(0, 16'hFFFF, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_ready", {63'd0, inReady}, 64'd0);
    chk("bp_valid", {63'd0, ValidOut}, 64'd1);
    chk("bp_a_min1", {56'd0, MinSig1}, 64'd10);
    chk("bp_a_min2", {56'd0, MinSig2}, 64'd11);
    chk("bp_a_idx", {58'd0, IdxMinSig1}, 64'd0);
    outReady = 1'b1;
    @(negedge clk);
    chk("bp_b_valid", {63'd0, ValidOut}, 64'd1);
    chk("bp_b_min1", {56'd0, MinSig1}, 64'd7);
    chk("bp_b_min2", {56'd0, MinSig2}, 64'd70);
    chk("bp_b_idx", {58'd0, IdxMinSig1}, 64'd4);
    chk("bp_b_ready", {63'd0, inReady}, 64'd1);
    @(negedge clk);
    chk("bp_done", {63'd0, ValidOut}, 64'd0);

    fill(8'd1);
    put(0, 16'hFFFF, 1'b1, 1'b0);
    chk("restart_err0", {63'd0, errOut}, 64'd0);
    fill(8'd80);
    e[2] = 8'hDF;
    put(0, 16'hFFFF, 1'b1, 1'b1);
    chk("restart_err1", {63'd0, errOut}, 64'd1);
    @(negedge clk);
    chk("restart_err_pulse", {63'd0, errOut}, 64'd0);
    expect_row("restart", 8'd33, 8'd80, 6'd2, 64'h0000_0000_0000_FFFB);

    fill(8'd90);
    e[15] = 8'd12;
    put(0, 16'hFFFF, 1'b0, 1'b1);
    chk("nofirst_err", {63'd0, errOut}, 64'd1);
    expect_row("nofirst", 8'd12, 8'd90, 6'd15, 64'd0);

    fill(8'd20);
    for (int b = 0; b < 4; b++) put(b, 16'hFFFF, b == 0, 1'b0);
    chk("ovf_err0", {63'd0, errOut}, 64'd0);
    put(0, 16'hFFFF, 1'b0, 1'b0);
    chk("ovf_err1", {63'd0, errOut}, 64'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= ValidOut;
    end
    chk("ovf_no_output", {63'd0, seen}, 64'd0);
    fill(8'd45);
    e[10] = 8'd44;
    put(0, 16'hFFFF, 1'b1, 1'b1);
    expect_row("ovf_recover", 8'd44, 8'd45, 6'd10, 64'd0);

    fill(8'd2);
    put(0, 16'hFFFF, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {63'd0, inReady}, 64'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= ValidOut;
    end
    chk("midrst_no_output", {63'd0, seen}, 64'd0);

    fill(8'd100);
    e[6] = 8'd0;
    e[9] = 8'd3;
    put(0, 16'hFFFF, 1'b1, 1'b1);
`ifdef OFFSET_MINSUM_EN
    expect_row("offset", 8'd0, 8'd2, 6'd6, 64'd0);
`else
    expect_row("offset", 8'd0, 8'd3, 6'd6, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
